// File: rtl/segled_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: register map,
// scan FSM encoding and CTRL field positions.
package segled_pkg;

  localparam int unsigned ADDR_DATA = 0;
  localparam int unsigned ADDR_CTRL = 1;
  localparam int unsigned ADDR_DIV  = 2;

  localparam int CTRL_EN_LSB  = 0;
  localparam int CTRL_DP_LSB  = 8;
  localparam int CTRL_GEN_BIT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

endpackage

// File: rtl/segled_scan_if.sv
// Write-only peripheral bus shared with the other segment-display registers.
interface segled_scan_if #(
  parameter int ADDRESS_WIDTH = 5
);
  logic                     wr;
  logic [ADDRESS_WIDTH-1:0] waddr;
  logic [31:0]              wdata;

  modport master (output wr, waddr, wdata);
  modport slave  (input  wr, waddr, wdata);
endinterface

// File: rtl/segled_hex7.sv
// Combinational hex nibble to seven-segment decoder, bit order {g,f,e,d,c,b,a}.
module segled_hex7 (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h00;
    case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end
endmodule

// File: rtl/segled_scan.sv
// Time-multiplexed seven-segment controller: register file, scan FSM with a
// programmable dwell and blanking gap, and registered pin drivers.
module segled_scan
  import segled_pkg::*;
#(
  parameter int          ADDRESS_WIDTH = 5,
  parameter int          DIGITS        = 8,
  parameter logic [15:0] DIV_RESET     = 16'd49999,
  parameter int          BLANK_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              rstn,
  segled_scan_if.slave      bus,
  output logic [7:0]        seg_pin,
  output logic [DIGITS-1:0] dig_sel
);

  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);
  localparam logic [2:0]  IDX_LAST   = 3'(DIGITS - 1);

  logic [31:0] data_q;
  logic [7:0]  en_q;
  logic [7:0]  dp_q;
  logic        gen_q;
  logic [15:0] div_q;

  logic wr_data, wr_ctrl, wr_div;

  assign wr_data = bus.wr && (bus.waddr == ADDRESS_WIDTH'(ADDR_DATA));
  assign wr_ctrl = bus.wr && (bus.waddr == ADDRESS_WIDTH'(ADDR_CTRL));
  assign wr_div  = bus.wr && (bus.waddr == ADDRESS_WIDTH'(ADDR_DIV));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= 32'h0;
      en_q   <= 8'hFF;
      dp_q   <= 8'h00;
      gen_q  <= 1'b0;
      div_q  <= DIV_RESET;
    end else begin
      if (wr_data) data_q <= bus.wdata;
      if (wr_ctrl) begin
        en_q  <= bus.wdata[CTRL_EN_LSB +: 8];
        dp_q  <= bus.wdata[CTRL_DP_LSB +: 8];
        gen_q <= bus.wdata[CTRL_GEN_BIT];
      end
      if (wr_div) div_q <= bus.wdata[15:0];
    end
  end

  state_t            state, state_nx;
  logic [2:0]        idx, idx_nx;
  logic [15:0]       cnt, cnt_nx;
  logic [3:0]        nibble;
  logic [6:0]        hex_seg;
  logic [7:0]        seg_nx;
  logic [DIGITS-1:0] dig_nx;

  assign nibble = data_q[{idx, 2'b00} +: 4];

  segled_hex7 u_hex7 (
    .nibble (nibble),
    .seg    (hex_seg)
  );

  // cnt doubles as the dwell counter in SHOW and the gap counter in BLANK
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    seg_nx   = 8'h00;
    dig_nx   = '0;
    if (!gen_q) begin
      state_nx = ST_IDLE;
      idx_nx   = 3'd0;
      cnt_nx   = 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nx = ST_SHOW;
          cnt_nx   = 16'd0;
        end
        ST_SHOW: begin
          if (cnt >= div_q) begin
            state_nx = ST_BLANK;
            cnt_nx   = 16'd0;
          end else begin
            cnt_nx = cnt + 16'd1;
          end
        end
        ST_BLANK: begin
          if (cnt >= BLANK_LAST) begin
            state_nx = ST_SHOW;
            cnt_nx   = 16'd0;
            idx_nx   = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
          end else begin
            cnt_nx = cnt + 16'd1;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
    // a masked digit keeps its slot but never drives its select line
    if (state == ST_SHOW) begin
      seg_nx = {dp_q[idx], hex_seg};
      if (en_q[idx]) dig_nx = DIGITS'(1) << idx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      idx     <= 3'd0;
      cnt     <= 16'd0;
      seg_pin <= 8'h00;
      dig_sel <= '0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      cnt     <= cnt_nx;
      seg_pin <= seg_nx;
      dig_sel <= dig_nx;
    end
  end

endmodule

// File: tb/tb_segled_scan.sv
// Bench for segled_scan: directed scan scenarios plus random bus traffic,
// checked every cycle against a slot-level model of the display.
module tb_segled_scan;

  localparam int DIGITS = 8;
  localparam int BLANK  = 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] seg_pin;
  logic [7:0] dig_sel;

  always #5 clk = ~clk;

  segled_scan_if #(.ADDRESS_WIDTH(5)) bus ();

  segled_scan #(
    .ADDRESS_WIDTH (5),
    .DIGITS        (DIGITS),
    .DIV_RESET     (16'd49999),
    .BLANK_CYCLES  (BLANK)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus),
    .seg_pin (seg_pin),
    .dig_sel (dig_sel)
  );

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // model: phase 0 = off, 1 = digit lit, 2 = gap; age = cycles already spent in phase
  logic [31:0] m_data;
  logic [7:0]  m_en, m_dp;
  logic        m_gen;
  int          m_div, m_phase, m_idx, m_age;
  logic [7:0]  e_seg, e_dig;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_data <= 32'h0; m_en <= 8'hFF; m_dp <= 8'h00; m_gen <= 1'b0; m_div <= 49999;
      m_phase <= 0; m_idx <= 0; m_age <= 0; e_seg <= 8'h00; e_dig <= 8'h00;
    end else begin
      if (m_phase == 1) begin
        e_seg <= {m_dp[m_idx], hex_tab[(m_data >> (4 * m_idx)) & 32'hF]};
        e_dig <= m_en[m_idx] ? 8'(1 << m_idx) : 8'h00;
      end else begin
        e_seg <= 8'h00;
        e_dig <= 8'h00;
      end
      if (!m_gen) begin
        m_phase <= 0; m_idx <= 0; m_age <= 0;
      end else if (m_phase == 0) begin
        m_phase <= 1; m_age <= 0;
      end else if (m_phase == 1) begin
        if (m_age >= m_div) begin m_phase <= 2; m_age <= 0; end
        else m_age <= m_age + 1;
      end else begin
        if (m_age >= BLANK - 1) begin m_phase <= 1; m_age <= 0; m_idx <= (m_idx + 1) % DIGITS; end
        else m_age <= m_age + 1;
      end
      if (bus.wr) begin
        case (bus.waddr)
          5'd0: m_data <= bus.wdata;
          5'd1: begin m_en <= bus.wdata[7:0]; m_dp <= bus.wdata[15:8]; m_gen <= bus.wdata[16]; end
          5'd2: m_div <= int'(bus.wdata[15:0]);
          default: ;
        endcase
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(negedge clk);
    checks++;
    if (seg_pin !== e_seg || dig_sel !== e_dig) begin
      errors++;
      $display("FAIL model_cmp t=%0t seg=%h dig=%h expected seg=%h dig=%h", $time, seg_pin, dig_sel, e_seg, e_dig);
    end
    checks++;
    if ($countones(dig_sel) > 1) begin
      errors++;
      $display("FAIL onehot t=%0t dig=%h expected at most one bit", $time, dig_sel);
    end
  endtask

  task automatic expect_pins(input string name, input logic [7:0] s, input logic [7:0] d);
    checks++;
    if (seg_pin !== s || dig_sel !== d) begin
      errors++;
      $display("FAIL %s t=%0t seg=%h dig=%h expected seg=%h dig=%h", name, $time, seg_pin, dig_sel, s, d);
    end
  endtask

  task automatic expect_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    bus.wr = 1'b1; bus.waddr = a; bus.wdata = d;
    tick();
    bus.wr = 1'b0;
  endtask

  task automatic wait_dig(input string name, input logic [7:0] d, input int lim);
    int n = 0;
    while (dig_sel !== d && n < lim) begin tick(); n++; end
    checks++;
    if (dig_sel !== d) begin
      errors++;
      $display("FAIL %s timeout dig=%h expected %h", name, dig_sel, d);
    end
  endtask

  task automatic wait_lit(input string name, input bit lit, input int lim);
    int n = 0;
    while ((dig_sel != 8'h00) != lit && n < lim) begin tick(); n++; end
    checks++;
    if ((dig_sel != 8'h00) != lit) begin
      errors++;
      $display("FAIL %s timeout dig=%h expected lit=%0d", name, dig_sel, lit);
    end
  endtask

  initial begin
    int n;
    rstn = 1'b0;
    bus.wr = 1'b0; bus.waddr = 5'd0; bus.wdata = 32'h0;
    repeat (3) tick();
    expect_pins("reset_state", 8'h00, 8'h00);
    rstn = 1'b1;
    repeat (3) tick();
    expect_pins("idle_disabled", 8'h00, 8'h00);

    // asynchronous reset in the middle of a scan
    wr_reg(5'd2, 32'd3);
    wr_reg(5'd1, 32'h000100FF);
    wait_dig("scan_start", 8'h01, 10);
    repeat (5) tick();
    #2 rstn = 1'b0;
    #1 expect_pins("async_reset", 8'h00, 8'h00);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    expect_pins("idle_after_reset", 8'h00, 8'h00);

    // full scan, DIV=3: 4 lit + 2 dark per digit, wrap after 48 cycles
    wr_reg(5'd2, 32'd3);
    wr_reg(5'd0, 32'h76543210);
    wr_reg(5'd1, 32'h000100FF);
    wait_dig("scan1_start", 8'h01, 10);
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < 4; c++) begin
        if (d != 0 || c != 0) tick();
        expect_pins($sformatf("scan1_d%0d_c%0d", d, c), {1'b0, hex_tab[d]}, 8'(1 << d));
      end
      for (int c = 0; c < 2; c++) begin
        tick();
        expect_pins($sformatf("scan1_gap%0d", d), 8'h00, 8'h00);
      end
    end
    tick();
    expect_pins("scan1_wrap", 8'h3F, 8'h01);

    // enable mask F0, dp mask 55
    wr_reg(5'd1, 32'h000155F0);
    wr_reg(5'd0, 32'h8888FFFF);
    wait_dig("mask_d4", 8'h10, 80);
    expect_pins("mask_d4_seg", 8'hFF, 8'h10);
    wait_dig("mask_d5", 8'h20, 10);
    expect_pins("mask_d5_seg", 8'h7F, 8'h20);

    // shrink DIV while count=10 in a long slot
    wr_reg(5'd1, 32'h000100FF);
    wr_reg(5'd2, 32'd20);
    wait_lit("div_dark", 1'b0, 200);
    wait_lit("div_lit", 1'b1, 10);
    repeat (9) tick();
    wr_reg(5'd2, 32'd2);
    tick();
    expect_int("div_cut_lit", int'(dig_sel != 8'h00), 1);
    tick();
    expect_pins("div_cut_gap", 8'h00, 8'h00);
    wait_lit("div3_lit", 1'b1, 10);
    n = 1;
    tick();
    while (dig_sel != 8'h00 && n < 50) begin n++; tick(); end
    expect_int("div3_slot_len", n, 3);

    // clear enable during the gap
    wait_lit("gap_lit", 1'b1, 10);
    repeat (2) tick();
    wr_reg(5'd1, 32'h000000FF);
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_pins("disabled_dark", 8'h00, 8'h00);
    end
    wr_reg(5'd1, 32'h000100FF);
    wait_dig("restart_d0", 8'h01, 10);
    expect_pins("restart_d0_seg", 8'h71, 8'h01);

    // unmapped address, then back-to-back DATA/CTRL writes
    wr_reg(5'd5, 32'h00000000);
    wr_reg(5'd5, $urandom);
    repeat (60) tick();
    wr_reg(5'd0, 32'h000000A5);
    wr_reg(5'd1, 32'h000101FF);
    wait_dig("b2b_d0", 8'h01, 100);
    expect_pins("b2b_d0_seg", 8'hED, 8'h01);

    // random traffic with occasional asynchronous reset pulses
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        logic [31:0] d;
        logic [4:0]  a;
        a = 5'($urandom_range(0, 7));
        d = $urandom;
        if (a == 5'd1) d[16] = ($urandom_range(0, 9) != 0);
        if (a == 5'd2) d[15:0] = 16'($urandom_range(0, 6));
        wr_reg(a, d);
      end else if ($urandom_range(0, 499) == 0) begin
        #2 rstn = 1'b0;
        #1 rstn = 1'b1;
        tick();
      end else begin
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
